scam_rr_nb_reader: RTL and testbench

//  Parametrised multi-channel reader for SCAM-style blocking ports. Polls NUM_CH blocking input channels

---
 rtl/scam_rr_nb_reader_pkg.sv | 18 +
 rtl/scam_rr_nb_reader_if.sv | 33 +++
 rtl/scam_rr_nb_reader.sv | 119 +++++++++++
 tb/tb_scam_rr_nb_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/scam_rr_nb_reader_pkg.sv
// Shared types and helpers for the round-robin SCAM channel reader.
//   state_t  : reader FSM state (READ = polling an input channel,
//              WRITE = offering the accumulator downstream)
//   next_ptr : round-robin successor of a channel index, wrapping at num_ch
package scam_rr_nb_reader_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Channel index after ptr, wrapping num_ch-1 back to 0.
  function automatic int unsigned next_ptr(input int unsigned ptr,
                                           input int unsigned num_ch);
    return (ptr == num_ch - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/scam_rr_nb_reader_if.sv
// Bus bundle between the reader, its NUM_CH producers and its consumer.
//   ch_in        : channel data, channel k at [k*DATA_W +: DATA_W]
//   ch_in_sync   : producer k has valid data
//   ch_in_notify : reader ready to take channel k (one-hot or zero)
//   m_in         : shared master input, always readable
//   out          : accumulator value offered downstream
//   out_sync     : consumer ready to take out
//   out_notify   : out is valid
//   nb_result    : per-channel outcome of the last read attempt
// Modports: slave = the reader's view, master = the environment's view.
interface scam_rr_nb_reader_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
);
  logic [NUM_CH*DATA_W-1:0] ch_in;
  logic [NUM_CH-1:0]        ch_in_sync;
  logic [NUM_CH-1:0]        ch_in_notify;
  logic [DATA_W-1:0]        m_in;
  logic [DATA_W-1:0]        out;
  logic                     out_sync;
  logic                     out_notify;
  logic [NUM_CH-1:0]        nb_result;

  modport slave (
    input  ch_in, ch_in_sync, m_in, out_sync,
    output ch_in_notify, out, out_notify, nb_result
  );

  modport master (
    output ch_in, ch_in_sync, m_in, out_sync,
    input  ch_in_notify, out, out_notify, nb_result
  );
endinterface

// File: rtl/scam_rr_nb_reader.sv
// Round-robin multi-channel reader for SCAM-style blocking ports.
// Polls NUM_CH input channels in turn; each accepted value plus the shared
// m_in is added into a signed accumulator, and every new accumulator value
// is offered once on the blocking output port.
// NB_MODE=0 waits on the current channel until its producer syncs;
// NB_MODE=1 gives each channel a single-cycle window, recording hit/miss
// in nb_result, then moves on.
// Ports:
//   clk : clock, all state updates on posedge
//   rst : asynchronous, active-low reset
//   bus : scam_rr_nb_reader_if.slave (channel, master input and output ports)
import scam_rr_nb_reader_pkg::*;

module scam_rr_nb_reader #(
  parameter int                       NUM_CH   = 4,
  parameter int                       DATA_W   = 32,
  parameter bit                       NB_MODE  = 1'b0,
  parameter logic signed [DATA_W-1:0] INIT_VAL = 1337
) (
  input  logic                  clk,
  input  logic                  rst,
  scam_rr_nb_reader_if.slave    bus
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                     state_reg, state_next;
  logic [PTR_W-1:0]           ptr_reg, ptr_next;
  logic signed [DATA_W-1:0]   acc_reg, acc_next;
  logic [DATA_W-1:0]          out_reg, out_next;
  logic                       out_notify_reg, out_notify_next;
  logic [NUM_CH-1:0]          ch_notify_reg, ch_notify_next;
  logic [NUM_CH-1:0]          nb_result_reg, nb_result_next;

  logic [PTR_W-1:0]           ptr_inc;
  logic [NUM_CH-1:0]          inc_onehot;
  logic signed [DATA_W-1:0]   ch_data [NUM_CH];
  logic signed [DATA_W-1:0]   sum;
  logic                       cur_sync;

  assign ptr_inc = PTR_W'(next_ptr(32'(ptr_reg), NUM_CH));

  // Unpack the flat channel bus and pre-decode the one-hot notify for the
  // channel after ptr, so the FSM can load it directly into the register.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_data[gi]    = bus.ch_in[gi*DATA_W +: DATA_W];
    assign inc_onehot[gi] = (ptr_inc == PTR_W'(gi));
  end

  // Two's-complement wrap is intended; no saturation.
  assign sum      = acc_reg + ch_data[ptr_reg] + $signed(bus.m_in);
  assign cur_sync = bus.ch_in_sync[ptr_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= READ;
      ptr_reg        <= '0;
      acc_reg        <= INIT_VAL;
      out_reg        <= '0;
      out_notify_reg <= 1'b0;
      ch_notify_reg  <= NUM_CH'(1);
      nb_result_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      acc_reg        <= acc_next;
      out_reg        <= out_next;
      out_notify_reg <= out_notify_next;
      ch_notify_reg  <= ch_notify_next;
      nb_result_reg  <= nb_result_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    acc_next        = acc_reg;
    out_next        = out_reg;
    out_notify_next = out_notify_reg;
    ch_notify_next  = ch_notify_reg;
    nb_result_next  = nb_result_reg;

    case (state_reg)
      // In READ the notify register always equals 1<<ptr, so the sync of
      // the current channel alone decides the handshake.
      READ: begin
        if (cur_sync) begin
          acc_next                = sum;
          out_next                = sum;
          nb_result_next[ptr_reg] = 1'b1;
          ch_notify_next          = '0;
          out_notify_next         = 1'b1;
          state_next              = WRITE;
        end else if (NB_MODE) begin
          nb_result_next[ptr_reg] = 1'b0;
          ptr_next                = ptr_inc;
          ch_notify_next          = inc_onehot;
        end
      end
      // out_notify is always high here; inputs are not notified so their
      // syncs cannot cause a transfer.
      WRITE: begin
        if (bus.out_sync) begin
          out_notify_next = 1'b0;
          ptr_next        = ptr_inc;
          ch_notify_next  = inc_onehot;
          state_next      = READ;
        end
      end
      default: state_next = READ;
    endcase
  end

  assign bus.ch_in_notify = ch_notify_reg;
  assign bus.out          = out_reg;
  assign bus.out_notify   = out_notify_reg;
  assign bus.nb_result    = nb_result_reg;

endmodule

// File: tb/tb_scam_rr_nb_reader.sv
// Self-checking bench for scam_rr_nb_reader with three instances:
//   u0 : NB_MODE=0, INIT_VAL=1337        (blocking wait, backpressure, reset)
//   u1 : NB_MODE=1, INIT_VAL=1337        (try-read rotation, table driven)
//   u2 : NB_MODE=0, INIT_VAL=32'h7FFFFFFF (signed wrap)
// Expected output values are queued when the producing input is driven and
// popped when the matching out_notify rising edge appears.
module tb_scam_rr_nb_reader;

  logic clk;
  logic rst;

  scam_rr_nb_reader_if #(.NUM_CH(4), .DATA_W(32)) if0 ();
  scam_rr_nb_reader_if #(.NUM_CH(4), .DATA_W(32)) if1 ();
  scam_rr_nb_reader_if #(.NUM_CH(4), .DATA_W(32)) if2 ();

  scam_rr_nb_reader #(.NUM_CH(4), .DATA_W(32), .NB_MODE(1'b0), .INIT_VAL(32'sd1337))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  scam_rr_nb_reader #(.NUM_CH(4), .DATA_W(32), .NB_MODE(1'b1), .INIT_VAL(32'sd1337))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  scam_rr_nb_reader #(.NUM_CH(4), .DATA_W(32), .NB_MODE(1'b0), .INIT_VAL(32'h7FFF_FFFF))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic on0_prev = 1'b0;
  logic on1_prev = 1'b0;
  logic on2_prev = 1'b0;

  typedef struct {
    logic [3:0]  sync;
    logic        out_sync;
    logic [3:0]  exp_notify;
    logic        exp_on;
    logic [3:0]  exp_nb;
    logic        push;
    logic [31:0] push_val;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [31:0] act, inout logic [31:0] q[$]);
    logic [31:0] e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got output %0h with nothing expected", name, act);
    end else begin
      e = q.pop_front();
      check(name, {32'd0, act}, {32'd0, e});
      $display("item %s out=%0h expected=%0h", name, act, e);
    end
  endtask

  task automatic monitor();
    if (if0.out_notify && !on0_prev) pop_check("u0_out", if0.out, q0);
    if (if1.out_notify && !on1_prev) pop_check("u1_out", if1.out, q1);
    if (if2.out_notify && !on2_prev) pop_check("u2_out", if2.out, q2);
    on0_prev = if0.out_notify;
    on1_prev = if1.out_notify;
    on2_prev = if2.out_notify;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_u0_notify"}, {60'd0, if0.ch_in_notify}, 64'h1);
    check({tag, "_u0_onotify"}, {63'd0, if0.out_notify}, 64'h0);
    check({tag, "_u0_out"}, {32'd0, if0.out}, 64'h0);
    check({tag, "_u0_nb"}, {60'd0, if0.nb_result}, 64'h0);
    check({tag, "_u1_notify"}, {60'd0, if1.ch_in_notify}, 64'h1);
    check({tag, "_u1_onotify"}, {63'd0, if1.out_notify}, 64'h0);
    check({tag, "_u2_notify"}, {60'd0, if2.ch_in_notify}, 64'h1);
    check({tag, "_u2_out"}, {32'd0, if2.out}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // u1 table: ch2 carries 10, m_in = -2; starts at ptr 0 right after reset
    tbl[0] = '{4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 32'd0};
    tbl[1] = '{4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 32'd0};
    tbl[2] = '{4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 32'd0};
    tbl[3] = '{4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 32'd0};
    tbl[4] = '{4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 32'd0};
    tbl[5] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 32'd0};
    tbl[6] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 4'b0100, 1'b1, 32'd1345};
    tbl[7] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 4'b0100, 1'b0, 32'd0};
    tbl[8] = '{4'b0000, 1'b1, 4'b1000, 1'b0, 4'b0100, 1'b0, 32'd0};
    tbl[9] = '{4'b0100, 1'b0, 4'b0001, 1'b0, 4'b0100, 1'b0, 32'd0};

    rst = 1'b0;
    if0.ch_in = '0; if0.ch_in_sync = '0; if0.m_in = '0; if0.out_sync = 1'b0;
    if1.ch_in = '0; if1.ch_in_sync = '0; if1.m_in = '0; if1.out_sync = 1'b0;
    if2.ch_in = '0; if2.ch_in_sync = '0; if2.m_in = '0; if2.out_sync = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b1;

    // u0 blocking wait: no sync for 10 cycles keeps notify on channel 0
    for (int i = 0; i < 10; i++) begin
      step();
      check("u0_wait_notify", {60'd0, if0.ch_in_notify}, 64'h1);
    end
    if0.ch_in[0*32 +: 32] = 32'd5;
    if0.m_in = 32'd3;
    if0.ch_in_sync = 4'b0001;
    q0.push_back(32'd1345);
    step();
    if0.ch_in_sync = 4'b0000;
    check("u0_hit_onotify", {63'd0, if0.out_notify}, 64'h1);
    check("u0_hit_nb", {60'd0, if0.nb_result}, 64'h1);
    check("u0_hit_notify", {60'd0, if0.ch_in_notify}, 64'h0);

    // u0 backpressure: syncs toggling while WRITE must change nothing
    for (int i = 0; i < 5; i++) begin
      if0.ch_in_sync = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      step();
      check("u0_bp_out", {32'd0, if0.out}, 64'd1345);
      check("u0_bp_onotify", {63'd0, if0.out_notify}, 64'h1);
      check("u0_bp_notify", {60'd0, if0.ch_in_notify}, 64'h0);
    end
    if0.ch_in_sync = 4'b0000;
    if0.out_sync = 1'b1;
    step();
    if0.out_sync = 1'b0;
    check("u0_release_notify", {60'd0, if0.ch_in_notify}, 64'h2);
    check("u0_release_onotify", {63'd0, if0.out_notify}, 64'h0);
    check("u0_release_out", {32'd0, if0.out}, 64'd1345);

    // u2 signed wrap in both directions
    if2.ch_in[0*32 +: 32] = 32'd1;
    if2.ch_in_sync = 4'b0001;
    q2.push_back(32'h8000_0000);
    step();
    if2.ch_in_sync = 4'b0000;
    if2.out_sync = 1'b1;
    step();
    if2.out_sync = 1'b0;
    check("u2_wrap_notify", {60'd0, if2.ch_in_notify}, 64'h2);
    if2.ch_in[1*32 +: 32] = 32'hFFFF_FFFF;
    if2.ch_in_sync = 4'b0010;
    q2.push_back(32'h7FFF_FFFF);
    step();
    if2.ch_in_sync = 4'b0000;
    if2.out_sync = 1'b1;
    step();
    if2.out_sync = 1'b0;

    // u0 second item on channel 1, then reset while it is still pending
    if0.ch_in[1*32 +: 32] = 32'd7;
    if0.ch_in_sync = 4'b0010;
    q0.push_back(32'd1355);
    step();
    if0.ch_in_sync = 4'b0000;
    step();
    check("u0_pending_onotify", {63'd0, if0.out_notify}, 64'h1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset("async");
    @(posedge clk);
    #1;
    monitor();
    if1.ch_in[2*32 +: 32] = 32'd10;
    if1.m_in = 32'hFFFF_FFFE;
    rst = 1'b1;

    // u1 try-read table, one row per cycle
    for (int i = 0; i < 10; i++) begin
      if1.ch_in_sync = tbl[i].sync;
      if1.out_sync = tbl[i].out_sync;
      if (tbl[i].push) q1.push_back(tbl[i].push_val);
      step();
      check($sformatf("u1_row%0d_notify", i), {60'd0, if1.ch_in_notify}, {60'd0, tbl[i].exp_notify});
      check($sformatf("u1_row%0d_onotify", i), {63'd0, if1.out_notify}, {63'd0, tbl[i].exp_on});
      check($sformatf("u1_row%0d_nb", i), {60'd0, if1.nb_result}, {60'd0, tbl[i].exp_nb});
    end
    if1.ch_in_sync = 4'b0000;
    if1.out_sync = 1'b0;

    // u0 accumulator restarted from 1337 after reset
    if0.ch_in[0*32 +: 32] = 32'd0;
    if0.m_in = 32'd0;
    if0.ch_in_sync = 4'b0001;
    q0.push_back(32'd1337);
    step();
    if0.ch_in_sync = 4'b0000;
    if0.out_sync = 1'b1;
    step();
    if0.out_sync = 1'b0;
    step();

    check("q0_drained", {32'd0, 32'(q0.size())}, 64'd0);
    check("q1_drained", {32'd0, 32'(q1.size())}, 64'd0);
    check("q2_drained", {32'd0, 32'(q2.size())}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
